xf100_ifu_fetch: RTL

- Instruction fetch stage directly upstream of xf100_exu; sources the instruction and PC that the EXU decodes.
- Generates sequential fetch addresses and issues them to the instruction memory over a valid/ready request channel.
- Accepts in-order responses into a 2-entry instruction buffer and presents each entry to the EXU with a valid/ready handshake.
- Handles redirects (branch/jump flush) from the EXU: buffered instructions are flushed and in-flight responses are discarded.

---
 rtl/xf100_ifu_fetch.sv | 80 ++++++++
 1 files changed

// File: rtl/xf100_ifu_fetch.sv
// xf100_ifu_fetch: sequential instruction fetch with credit-limited requests,
// a 2-entry instruction buffer and redirect flush of in-flight responses.
module xf100_ifu_fetch #(
  parameter int PC_SIZE = 32,
  parameter int INSTR_SIZE = 32,
  parameter logic [PC_SIZE-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ifu_i_redirect_valid,
  input  logic [PC_SIZE-1:0]    ifu_i_redirect_pc,
  output logic                  ifu_o_req_valid,
  input  logic                  ifu_i_req_ready,
  output logic [PC_SIZE-1:0]    ifu_o_req_addr,
  input  logic                  ifu_i_rsp_valid,
  input  logic [INSTR_SIZE-1:0] ifu_i_rsp_instr,
  input  logic                  ifu_i_rsp_err,
  output logic                  ifu_o_instr_valid,
  input  logic                  ifu_i_instr_ready,
  output logic [INSTR_SIZE-1:0] ifu_o_instr,
  output logic [PC_SIZE-1:0]    ifu_o_pc,
  output logic                  ifu_o_instr_err
);
  logic [PC_SIZE-1:0] req_pc, rsp_pc, redir_pc;
  logic [1:0] outst_cnt, drop_cnt, fifo_cnt, outst_nxt;
  logic [INSTR_SIZE-1:0] f_instr [2];
  logic [PC_SIZE-1:0] f_pc [2];
  logic [1:0] f_err;
  logic rd_ptr, wr_ptr, req_fire, push, pop, drop;
  logic unused_redir_lsb;
  assign unused_redir_lsb = ^ifu_i_redirect_pc[1:0];
  assign redir_pc = {ifu_i_redirect_pc[PC_SIZE-1:2], 2'b00};
  // Outstanding requests count against buffer space so responses never stall
  assign ifu_o_req_valid = !rst && !ifu_i_redirect_valid && (({1'b0, outst_cnt} + {1'b0, fifo_cnt}) < 3'd2);
  assign ifu_o_req_addr = rst ? '0 : req_pc;
  assign req_fire = ifu_o_req_valid && ifu_i_req_ready;
  assign drop = ifu_i_rsp_valid && (drop_cnt != 2'd0 || ifu_i_redirect_valid);
  assign push = ifu_i_rsp_valid && !drop;
  assign ifu_o_instr_valid = !rst && (fifo_cnt != 2'd0) && !ifu_i_redirect_valid;
  assign pop = ifu_o_instr_valid && ifu_i_instr_ready;
  assign ifu_o_instr = rst ? '0 : f_instr[rd_ptr];
  assign ifu_o_pc = rst ? '0 : f_pc[rd_ptr];
  assign ifu_o_instr_err = !rst && f_err[rd_ptr];
  assign outst_nxt = outst_cnt + {1'b0, req_fire} - {1'b0, ifu_i_rsp_valid};
  always_ff @(posedge clk) begin
    if (rst) begin
      req_pc <= RESET_PC;
      rsp_pc <= RESET_PC;
      outst_cnt <= 2'd0;
      drop_cnt <= 2'd0;
      fifo_cnt <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      outst_cnt <= outst_nxt;
      if (ifu_i_redirect_valid) begin
        req_pc <= redir_pc;
        rsp_pc <= redir_pc;
        drop_cnt <= outst_nxt;
        fifo_cnt <= 2'd0;
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
      end else begin
        if (req_fire) req_pc <= req_pc + PC_SIZE'(4);
        if (push) rsp_pc <= rsp_pc + PC_SIZE'(4);
        if (ifu_i_rsp_valid && drop_cnt != 2'd0) drop_cnt <= drop_cnt - 2'd1;
        if (push) wr_ptr <= !wr_ptr;
        if (pop) rd_ptr <= !rd_ptr;
        fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      f_instr[wr_ptr] <= ifu_i_rsp_instr;
      f_pc[wr_ptr] <= rsp_pc;
      f_err[wr_ptr] <= ifu_i_rsp_err;
    end
  end
endmodule
